// File: rtl/bus_arbiter_pkg.sv
// Shared types for the internal bus arbiter: FSM states, slave IDs, ID decode.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package bus_arb_pkg;

  localparam int SLAVE_ID_WIDTH = 2;

  typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} arb_state_t;

  typedef enum logic [SLAVE_ID_WIDTH-1:0] {
    no_slave,
    slave_1,
    slave_2,
    slave_3
  } slave_t;

  // Slave ID to one-hot enable over the largest supported slave count.
  function automatic logic [2:0] slave_onehot(input slave_t id);
    case (id)
      slave_1: return 3'b001;
      slave_2: return 3'b010;
      slave_3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// Latency: none (wiring only).
// Backpressure: masters hold req until they see grant; done ends ownership.
interface bus_arbiter_if import bus_arb_pkg::*; #(
  parameter int INT_MASTER_COUNT = 2,
  parameter int INT_SLAVE_COUNT  = 3,
  parameter int AW = (INT_MASTER_COUNT > 1) ? $clog2(INT_MASTER_COUNT) : 1
) ();

  logic                                             enable;
  logic [INT_MASTER_COUNT-1:0]                      req;
  logic [INT_MASTER_COUNT-1:0][SLAVE_ID_WIDTH-1:0]  slave_sel;
  logic [INT_MASTER_COUNT-1:0]                      done;
  logic [INT_MASTER_COUNT-1:0]                      grant;
  logic [INT_SLAVE_COUNT-1:0]                       slave_en;
  logic [AW-1:0]                                    active_master;
  logic                                             bus_busy;
  logic                                             bad_sel;
  logic [INT_MASTER_COUNT-1:0]                      preempt;

  // Requesting side.
  modport master (
    output enable, req, slave_sel, done,
    input  grant, slave_en, active_master, bus_busy, bad_sel, preempt
  );

  // Arbiter side.
  modport slave (
    input  enable, req, slave_sel, done,
    output grant, slave_en, active_master, bus_busy, bad_sel, preempt
  );

endinterface

// File: rtl/bus_arbiter_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping, as one-hot plus index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the winner.
module rr_priority_picker #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] win,
  output logic [W-1:0] win_idx,
  output logic         any
);

  // Scan from lowest priority back towards ptr so the slot nearest ptr overrides.
  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        win = '0;
        win[(int'(ptr) + i) % N] = 1'b1;
        win_idx = W'((int'(ptr) + i) % N);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal bus; routes the owner to its slave. Optional hold timeout: BUS_ARBITER_TIMEOUT_EN.
// Latency: req to grant 1 cycle from IDLE; done to grant low 1 cycle, then one RELEASE and one IDLE cycle.
// Backpressure: a master keeps req high until granted; ownership ends only on done or req drop.
module bus_arbiter import bus_arb_pkg::*; #(
  parameter int INT_MASTER_COUNT   = 2,
  parameter int INT_SLAVE_COUNT    = 3,
  parameter int FIRST_START_MASTER = 0,
  parameter int MAX_HOLD_CYCLES    = 256
) (
  input logic        clk,
  input logic        rstN,
  bus_arbiter_if.slave bus
);

  localparam int AW = (INT_MASTER_COUNT > 1) ? $clog2(INT_MASTER_COUNT) : 1;

  if (INT_MASTER_COUNT < 2 || INT_MASTER_COUNT > 4 || INT_SLAVE_COUNT < 1 ||
      INT_SLAVE_COUNT > 3 || FIRST_START_MASTER >= INT_MASTER_COUNT || MAX_HOLD_CYCLES < 2) begin : g_param_check
    $error("bus_arbiter: parameter out of range");
  end

  arb_state_t                  state_q, state_n;
  logic [INT_MASTER_COUNT-1:0] grant_q, grant_n;
  logic [INT_SLAVE_COUNT-1:0]  slave_en_q, slave_en_n;
  logic [AW-1:0]               owner_q, owner_n;
  logic [AW-1:0]               ptr_q, ptr_n;
  logic                        busy_q;
  logic                        bad_sel_q;
  logic [INT_MASTER_COUNT-1:0] bad_prev_q;

  logic [INT_MASTER_COUNT-1:0] id_ok, valid, bad_now;
  logic [INT_MASTER_COUNT-1:0] pick_win;
  logic [AW-1:0]               pick_idx;
  logic                        pick_any;
  logic [2:0]                  pick_en;

  // A request only competes when its slave ID names an existing slave.
  always_comb begin
    id_ok = '0;
    for (int i = 0; i < INT_MASTER_COUNT; i++) begin
      id_ok[i] = (bus.slave_sel[i] != '0) && (int'(bus.slave_sel[i]) <= INT_SLAVE_COUNT);
    end
  end

  assign valid   = bus.req & id_ok;
  assign bad_now = bus.req & ~id_ok;
  assign pick_en = slave_onehot(slave_t'(bus.slave_sel[pick_idx]));

  rr_priority_picker #(.N(INT_MASTER_COUNT), .W(AW)) u_pick (
    .req     (valid),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Next-state and next-output computation; grant/slave_en only change on state transitions.
  always_comb begin
    state_n    = state_q;
    grant_n    = grant_q;
    slave_en_n = slave_en_q;
    owner_n    = owner_q;
    ptr_n      = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.enable && pick_any) begin
          state_n    = GRANTED;
          grant_n    = pick_win;
          slave_en_n = pick_en[INT_SLAVE_COUNT-1:0];
          owner_n    = pick_idx;
        end
      end
      GRANTED: begin
        if (bus.done[owner_q] || !bus.req[owner_q]) begin
          state_n    = RELEASE;
          grant_n    = '0;
          slave_en_n = '0;
        end
      end
      RELEASE: begin
        state_n = IDLE;
        ptr_n   = (owner_q == AW'(INT_MASTER_COUNT - 1)) ? '0 : owner_q + 1'b1;
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        slave_en_n = '0;
      end
    endcase
  end

  // State and registered outputs; reset puts FIRST_START_MASTER at top priority.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      slave_en_q <= '0;
      owner_q    <= AW'(FIRST_START_MASTER);
      ptr_q      <= AW'(FIRST_START_MASTER);
      busy_q     <= 1'b0;
      bad_sel_q  <= 1'b0;
      bad_prev_q <= '0;
    end else begin
      state_q    <= state_n;
      grant_q    <= grant_n;
      slave_en_q <= slave_en_n;
      owner_q    <= owner_n;
      ptr_q      <= ptr_n;
      busy_q     <= (state_n == GRANTED);
      bad_sel_q  <= |(bad_now & ~bad_prev_q);
      bad_prev_q <= bad_now;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.slave_en      = slave_en_q;
  assign bus.active_master = owner_q;
  assign bus.bus_busy      = busy_q;
  assign bus.bad_sel       = bad_sel_q;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD_CYCLES) + 1;

  logic [HW-1:0]               hold_q, hold_n;
  logic [INT_MASTER_COUNT-1:0] preempt_q, preempt_n;

  // Hold counter saturates at the limit; preempt is sticky until the owner lets go.
  always_comb begin
    hold_n    = hold_q;
    preempt_n = preempt_q;
    if (state_q == GRANTED) begin
      if (hold_q < HW'(MAX_HOLD_CYCLES - 1)) hold_n = hold_q + 1'b1;
      if (state_n != GRANTED) begin
        preempt_n = '0;
      end else if (hold_n == HW'(MAX_HOLD_CYCLES - 1) && |(valid & ~grant_q)) begin
        preempt_n = grant_q;
      end
    end else begin
      hold_n    = '0;
      preempt_n = '0;
    end
  end

  // Hold counter and preempt registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hold_q    <= '0;
      preempt_q <= '0;
    end else begin
      hold_q    <= hold_n;
      preempt_q <= preempt_n;
    end
  end

  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: two instances (3 slaves/first=0 and 2 slaves/first=1).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.INT_MASTER_COUNT(2), .INT_SLAVE_COUNT(3)) bif  ();
  bus_arbiter_if #(.INT_MASTER_COUNT(2), .INT_SLAVE_COUNT(2)) bif2 ();

  bus_arbiter #(
    .INT_MASTER_COUNT(2), .INT_SLAVE_COUNT(3), .FIRST_START_MASTER(0), .MAX_HOLD_CYCLES(8)
  ) dut (.clk(clk), .rstN(rstN), .bus(bif));

  bus_arbiter #(
    .INT_MASTER_COUNT(2), .INT_SLAVE_COUNT(2), .FIRST_START_MASTER(1), .MAX_HOLD_CYCLES(8)
  ) dut2 (.clk(clk), .rstN(rstN), .bus(bif2));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstN = 1'b0;
    bif.enable  = 1'b0; bif.req  = '0; bif.slave_sel  = '0; bif.done  = '0;
    bif2.enable = 1'b0; bif2.req = '0; bif2.slave_sel = '0; bif2.done = '0;
    step(2);
    chk("rst_grant",    bif.grant, 8'h00);
    chk("rst_slave_en", bif.slave_en, 8'h00);
    chk("rst_busy",     bif.bus_busy, 8'h00);
    chk("rst_bad_sel",  bif.bad_sel, 8'h00);
    chk("rst_preempt",  bif.preempt, 8'h00);
    chk("rst_active",   bif.active_master, 8'h00);
    chk("rst_active2",  bif2.active_master, 8'h01);
    rstN = 1'b1;
    step(1);

    // Single request, done pulse, two-cycle gap before regrant.
    bif.enable = 1'b1; bif.req = 2'b01; bif.slave_sel[0] = 2'd1;
    step(1);
    chk("single_grant",    bif.grant, 8'h01);
    chk("single_slave_en", bif.slave_en, 8'h01);
    chk("single_busy",     bif.bus_busy, 8'h01);
    bif.done = 2'b01;
    step(1);
    bif.done = 2'b00;
    chk("release_grant",    bif.grant, 8'h00);
    chk("release_slave_en", bif.slave_en, 8'h00);
    chk("release_busy",     bif.bus_busy, 8'h00);
    step(1);
    chk("gap_grant", bif.grant, 8'h00);
    step(1);
    chk("regrant", bif.grant, 8'h01);
    bif.req = 2'b00;
    step(1);
    chk("req_drop_release", bif.grant, 8'h00);
    step(1);

    // Contention from a fresh reset.
    rstN = 1'b0; #1; rstN = 1'b1;
    step(1);
    bif.req = 2'b11; bif.slave_sel[0] = 2'd1; bif.slave_sel[1] = 2'd2;
    step(1);
    chk("cont_grant0",    bif.grant, 8'h01);
    chk("cont_slave_en0", bif.slave_en, 8'h01);
    chk("cont_active0",   bif.active_master, 8'h00);
    bif.slave_sel[0] = 2'd3;
    step(1);
    chk("latched_sel", bif.slave_en, 8'h01);
    bif.done = 2'b10;
    step(1);
    bif.done = 2'b00;
    chk("nonowner_done", bif.grant, 8'h01);
    bif.done = 2'b01;
    step(1);
    bif.done = 2'b00;
    chk("cont_release", bif.grant, 8'h00);
    step(1);
    chk("cont_gap", bif.grant, 8'h00);
    step(1);
    chk("cont_grant1",    bif.grant, 8'h02);
    chk("cont_slave_en1", bif.slave_en, 8'h02);
    chk("cont_active1",   bif.active_master, 8'h01);

    // Enable low keeps the current owner but blocks new grants.
    bif.enable = 1'b0;
    step(1);
    chk("en_low_keep", bif.grant, 8'h02);
    bif.done = 2'b10;
    step(1);
    bif.done = 2'b00;
    chk("en_low_release", bif.grant, 8'h00);
    step(2);
    chk("en_low_no_grant", bif.grant, 8'h00);
    chk("en_low_busy",     bif.bus_busy, 8'h00);
    bif.enable = 1'b1;
    step(1);
    chk("en_high_grant",    bif.grant, 8'h01);
    chk("en_high_slave_en", bif.slave_en, 8'h04);

    // Fairness: both keep requesting, owners alternate.
    for (int k = 0; k < 4; k++) begin
      chk("fair_owner", bif.grant, (k % 2 == 0) ? 8'h01 : 8'h02);
      step(2);
      bif.done[k % 2] = 1'b1;
      step(1);
      bif.done = 2'b00;
      chk("fair_gap", bif.grant, 8'h00);
      step(2);
    end
    chk("fair_final", bif.grant, 8'h01);

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Master0 holds while master1 waits: preempt rises on grant cycle 8.
    for (int c = 1; c < 8; c++) begin
      chk("preempt_early", bif.preempt, 8'h00);
      step(1);
    end
    chk("preempt_cycle8", bif.preempt, 8'h01);
    step(3);
    chk("preempt_sticky", bif.preempt, 8'h01);
    chk("not_revoked",    bif.grant, 8'h01);
    bif.done = 2'b01;
    step(1);
    bif.done = 2'b00;
    chk("preempt_cleared", bif.preempt, 8'h00);
    step(2);
    bif.req = 2'b10;
    step(20);
    chk("preempt_no_peer", bif.preempt, 8'h00);
    chk("grant_no_peer",   bif.grant, 8'h02);
`else
    step(20);
    chk("no_timeout_preempt", bif.preempt, 8'h00);
    chk("no_timeout_grant",   bif.grant, 8'h01);
`endif
    bif.req = 2'b00;
    step(2);

    // Invalid slave ID 0 on master1: never granted, one bad_sel pulse per rising request.
    bif.req = 2'b10; bif.slave_sel[1] = 2'd0;
    step(1);
    chk("bad0_pulse", bif.bad_sel, 8'h01);
    chk("bad0_grant", bif.grant, 8'h00);
    step(1);
    chk("bad0_single", bif.bad_sel, 8'h00);
    step(2);
    chk("bad0_never", bif.grant, 8'h00);
    bif.req = 2'b00;
    step(1);
    bif.req = 2'b10;
    step(1);
    chk("bad0_again", bif.bad_sel, 8'h01);
    bif.req = 2'b00;
    step(1);

    // ID 3 with only two slaves.
    bif2.enable = 1'b1; bif2.req = 2'b01; bif2.slave_sel[0] = 2'd3;
    step(1);
    chk("bad3_pulse", bif2.bad_sel, 8'h01);
    chk("bad3_grant", bif2.grant, 8'h00);
    step(2);
    chk("bad3_single", bif2.bad_sel, 8'h00);
    chk("bad3_never",  bif2.grant, 8'h00);
    bif2.slave_sel[0] = 2'd2;
    step(1);
    chk("fix_grant",    bif2.grant, 8'h01);
    chk("fix_slave_en", bif2.slave_en, 8'h02);
    bif2.req = 2'b00;
    step(2);

    // Reset in the middle of a grant.
    bif2.req = 2'b11; bif2.slave_sel[0] = 2'd1; bif2.slave_sel[1] = 2'd2;
    bif.req = 2'b01; bif.slave_sel[0] = 2'd1;
    step(1);
    chk("pre_rst_grant2a", bif2.grant, 8'h02);
    bif2.done = 2'b10;
    step(1);
    bif2.done = 2'b00;
    step(2);
    chk("pre_rst_grant2b", bif2.grant, 8'h01);
    chk("pre_rst_grant1",  bif.grant, 8'h01);
    rstN = 1'b0;
    #1;
    chk("async_grant",    bif.grant, 8'h00);
    chk("async_slave_en", bif.slave_en, 8'h00);
    chk("async_busy",     bif.bus_busy, 8'h00);
    chk("async_grant2",   bif2.grant, 8'h00);
    chk("async_active2",  bif2.active_master, 8'h01);
    rstN = 1'b1;
    step(1);
    chk("post_rst_grant2",    bif2.grant, 8'h02);
    chk("post_rst_slave_en2", bif2.slave_en, 8'h02);
    chk("post_rst_grant1",    bif.grant, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
